// File: rtl/game_pkg.sv
// Shared types and constants for the game-level controller.
// The card count fixes the widths of the hidden mask and the pairs count.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StWin  = 2'd2,
    StLose = 2'd3
  } game_state_t;

  localparam int unsigned NUM_CARDS    = 36;
  localparam int unsigned MATCH_POINTS = 10;
  localparam int unsigned MISS_PENALTY = 5;

  function automatic logic [5:0] popcount36(input logic [NUM_CARDS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bcd_score.sv
// Three-digit BCD score accumulator.
// Adding saturates at 999, subtracting floors at 000, and clear has the highest priority.
module bcd_score
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        add,
  input  logic        sub,
  input  logic        clr,
  output logic [11:0] score_bcd
);

  localparam logic [3:0] Pen      = 4'(MISS_PENALTY);
  localparam logic [3:0] PenBorrow = 4'(10 - MISS_PENALTY);

  logic [11:0] score_q, score_d;
  logic [3:0]  d2, d1, d0;

  assign d2 = score_q[11:8];
  assign d1 = score_q[7:4];
  assign d0 = score_q[3:0];

  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = 12'h000;
    end else if (add) begin
      // Points land in the tens digit, so 990..999 all saturate.
      if (d2 == 4'd9 && d1 == 4'd9) begin
        score_d = 12'h999;
      end else if (d1 == 4'd9) begin
        score_d = {d2 + 4'd1, 4'd0, d0};
      end else begin
        score_d = {d2, d1 + 4'd1, d0};
      end
    end else if (sub) begin
      if (d2 == 4'd0 && d1 == 4'd0 && d0 < Pen) begin
        score_d = 12'h000;
      end else if (d0 >= Pen) begin
        score_d = {d2, d1, d0 - Pen};
      end else if (d1 == 4'd0) begin
        score_d = {d2 - 4'd1, 4'd9, d0 + PenBorrow};
      end else begin
        score_d = {d2, d1 - 4'd1, d0 + PenBorrow};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= 12'h000;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_bcd = score_q;

endmodule

// File: rtl/game_status.sv
// Game sequencer: idle/play/win/lose FSM, per-second countdown and score/pairs reporting.
// All outputs come from registers, so nothing passes combinationally from an input.
module game_status
  import game_pkg::*;
#(
  parameter int unsigned TIME_LIMIT_S = 99,
  parameter int unsigned TICKS_PER_S  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ms,
  input  logic                 mf,
  input  logic [NUM_CARDS-1:0] hidden_bus,
  output logic [1:0]           state,
  output logic                 play_en,
  output logic [7:0]           time_bcd,
  output logic [11:0]          score_bcd,
  output logic [4:0]           pairs_left
);

  localparam int unsigned TickW = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICKS_PER_S - 1);
  localparam logic [7:0] TimeInit = {4'(TIME_LIMIT_S / 10), 4'(TIME_LIMIT_S % 10)};
  localparam logic [4:0] PairsInit = 5'(NUM_CARDS / 2);

  game_state_t      state_q, state_d;
  logic             start_q, start_re;
  logic             all_hidden_q;
  logic [4:0]       pairs_q, pairs_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [7:0]       time_q, time_d;
  logic             wrap, in_play, in_end;
  logic             score_add, score_sub, score_clr;

  assign start_re = start & ~start_q;
  assign wrap     = (tick_q == TickMax);
  assign in_play  = (state_q == StPlay);
  assign in_end   = (state_q == StWin) || (state_q == StLose);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_re) state_d = StPlay;
      StPlay: begin
        // Win is checked first so a completed board beats the final timeout.
        if (all_hidden_q) begin
          state_d = StWin;
        end else if (wrap && time_q == 8'h01) begin
          state_d = StLose;
        end
      end
      StWin, StLose: if (start_re) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    state   = state_q;
    play_en = in_play;
  end

  always_comb begin
    tick_d = tick_q;
    time_d = time_q;
    if (state_q == StIdle || (in_end && start_re)) begin
      tick_d = '0;
      time_d = TimeInit;
    end else if (in_play && state_d == StPlay) begin
      tick_d = wrap ? '0 : tick_q + TickW'(1);
      if (wrap) begin
        time_d = (time_q[3:0] == 4'd0) ? {time_q[7:4] - 4'd1, 4'd9}
                                       : {time_q[7:4], time_q[3:0] - 4'd1};
      end
    end
  end

  assign pairs_d = 5'((NUM_CARDS - 32'(popcount36(hidden_bus))) >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b1;
      all_hidden_q <= 1'b0;
      pairs_q      <= PairsInit;
      tick_q       <= '0;
      time_q       <= TimeInit;
    end else begin
      start_q      <= start;
      all_hidden_q <= &hidden_bus;
      pairs_q      <= pairs_d;
      tick_q       <= tick_d;
      time_q       <= time_d;
    end
  end

  assign score_add = in_play & ms;
  assign score_sub = in_play & mf & ~ms;
  assign score_clr = (state_q == StIdle) | (in_end & start_re);

  bcd_score u_score (
    .clk       (clk),
    .rst       (rst),
    .add       (score_add),
    .sub       (score_sub),
    .clr       (score_clr),
    .score_bcd (score_bcd)
  );

  assign time_bcd   = time_q;
  assign pairs_left = pairs_q;

endmodule

// File: tb/tb_game_status.sv
// Directed bench: a short-game instance (3 s x 4 ticks) and a default instance (99 s x 100 ticks).
module tb_game_status;

  logic clk = 1'b0;
  logic rst;

  logic        s_start, s_ms, s_mf;
  logic [35:0] s_hid;
  logic [1:0]  s_state;
  logic        s_play_en;
  logic [7:0]  s_time;
  logic [11:0] s_score;
  logic [4:0]  s_pairs;

  logic        b_start, b_ms, b_mf;
  logic [35:0] b_hid;
  logic [1:0]  b_state;
  logic        b_play_en;
  logic [7:0]  b_time;
  logic [11:0] b_score;
  logic [4:0]  b_pairs;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  game_status #(.TIME_LIMIT_S(3), .TICKS_PER_S(4)) u_small (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .ms         (s_ms),
    .mf         (s_mf),
    .hidden_bus (s_hid),
    .state      (s_state),
    .play_en    (s_play_en),
    .time_bcd   (s_time),
    .score_bcd  (s_score),
    .pairs_left (s_pairs)
  );

  game_status u_big (
    .clk        (clk),
    .rst        (rst),
    .start      (b_start),
    .ms         (b_ms),
    .mf         (b_mf),
    .hidden_bus (b_hid),
    .state      (b_state),
    .play_en    (b_play_en),
    .time_bcd   (b_time),
    .score_bcd  (b_score),
    .pairs_left (b_pairs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    s_start = 1'b0; s_ms = 1'b0; s_mf = 1'b0; s_hid = '0;
    b_start = 1'b0; b_ms = 1'b0; b_mf = 1'b0; b_hid = '0;
    step(2);
    check("rst_s_state", 32'(s_state), 32'd0);
    check("rst_s_play_en", 32'(s_play_en), 32'd0);
    check("rst_s_time", 32'(s_time), 32'h03);
    check("rst_s_score", 32'(s_score), 32'h000);
    check("rst_s_pairs", 32'(s_pairs), 32'd18);
    check("rst_b_state", 32'(b_state), 32'd0);
    check("rst_b_time", 32'(b_time), 32'h99);
    check("rst_b_score", 32'(b_score), 32'h000);
    check("rst_b_pairs", 32'(b_pairs), 32'd18);
    rst = 1'b1;
    step(1);

    // Short game: start, score sequence and timeout.
    s_start = 1'b1; step(1); s_start = 1'b0;
    check("s_start_state", 32'(s_state), 32'd1);
    check("s_start_play_en", 32'(s_play_en), 32'd1);
    check("s_time_03", 32'(s_time), 32'h03);
    s_ms = 1'b1; step(1); check("s_ms1", 32'(s_score), 32'h010);
    step(1); check("s_ms2", 32'(s_score), 32'h020);
    s_ms = 1'b0; s_mf = 1'b1;
    step(1); check("s_mf1", 32'(s_score), 32'h015);
    check("s_time_still_03", 32'(s_time), 32'h03);
    step(1); check("s_mf2", 32'(s_score), 32'h010);
    check("s_time_02", 32'(s_time), 32'h02);
    step(1); check("s_mf3", 32'(s_score), 32'h005);
    step(1); check("s_mf4", 32'(s_score), 32'h000);
    step(1); check("s_mf_floor", 32'(s_score), 32'h000);
    s_ms = 1'b1;
    step(1); check("s_ms_and_mf", 32'(s_score), 32'h010);
    check("s_time_01", 32'(s_time), 32'h01);
    s_ms = 1'b0; s_mf = 1'b0;
    step(3); check("s_still_play_11", 32'(s_state), 32'd1);
    step(1); check("s_lose_12", 32'(s_state), 32'd3);
    check("s_lose_play_en", 32'(s_play_en), 32'd0);
    s_ms = 1'b1; step(1); s_ms = 1'b0;
    check("s_lose_ms_ignored", 32'(s_score), 32'h010);
    check("s_lose_held", 32'(s_state), 32'd3);

    // Restart: first pulse to IDLE, second to PLAY.
    s_start = 1'b1; step(1); s_start = 1'b0;
    check("s_restart_idle", 32'(s_state), 32'd0);
    check("s_restart_time", 32'(s_time), 32'h03);
    check("s_restart_score", 32'(s_score), 32'h000);
    step(1);
    s_start = 1'b1; step(1); s_start = 1'b0;
    check("s_replay", 32'(s_state), 32'd1);

    // All cards removed during the cycle before the final wrap: WIN beats LOSE.
    step(10);
    s_hid = '1;
    step(1);
    check("s_win_n1_state", 32'(s_state), 32'd1);
    check("s_win_pairs0", 32'(s_pairs), 32'd0);
    step(1);
    check("s_win_state", 32'(s_state), 32'd2);
    check("s_win_play_en", 32'(s_play_en), 32'd0);
    s_start = 1'b1; step(1); s_start = 1'b0;
    check("s_win_to_idle", 32'(s_state), 32'd0);
    s_hid = 36'h00000000F;
    step(1);
    check("s_pairs16", 32'(s_pairs), 32'd16);

    // Default instance: saturation and the 10 -> 09 borrow.
    b_start = 1'b1; step(1); b_start = 1'b0;
    check("b_start_state", 32'(b_state), 32'd1);
    b_ms = 1'b1; step(99); b_ms = 1'b0;
    check("b_score_990", 32'(b_score), 32'h990);
    b_mf = 1'b1; step(1); b_mf = 1'b0;
    check("b_score_985", 32'(b_score), 32'h985);
    b_ms = 1'b1; step(1);
    check("b_score_995", 32'(b_score), 32'h995);
    step(1);
    check("b_score_sat", 32'(b_score), 32'h999);
    step(1); b_ms = 1'b0;
    check("b_score_sat_hold", 32'(b_score), 32'h999);
    step(8999 - 103);
    check("b_time_10", 32'(b_time), 32'h10);
    step(1);
    check("b_time_09", 32'(b_time), 32'h09);
    check("b_still_play", 32'(b_state), 32'd1);

    // Asynchronous reset mid-game.
    #1 rst = 1'b0;
    #1;
    check("arst_state", 32'(b_state), 32'd0);
    check("arst_play_en", 32'(b_play_en), 32'd0);
    check("arst_time", 32'(b_time), 32'h99);
    check("arst_score", 32'(b_score), 32'h000);
    check("arst_pairs", 32'(b_pairs), 32'd18);
    b_start = 1'b1; s_start = 1'b1;
    step(2);
    rst = 1'b1;
    step(3);
    check("held_start_b", 32'(b_state), 32'd0);
    check("held_start_s", 32'(s_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
